ram8_arbiter: RTL and testbench
===============================

Name: ram8_arbiter

Overview:
- Two-requester controller in front of one ram8 instance: 8 words x 8 bits, combinational read, write on clk edge when load=1.
- After reset it clears all 8 words. It then shares the single RAM port between requester A (CPU side) and requester B (loader/DMA side) using round-robin arbitration.
- It drives ram8's in/addr/load and samples ram8's outp.

Parameters:
- WIDTH, 8, data word width; matches ram8.
- AW, 3, address width; DEPTH = 2**AW = 8 words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  requester A: access request; held until a_gnt.
- a_we  in  1  requester A: 1 = write, 0 = read.
- a_addr  in  AW  requester A: word address.
- a_wdata  in  WIDTH  requester A: write data.
- a_gnt  out  1  requester A: access performed this cycle.
- a_rvalid  out  1  requester A: read data valid, 1-cycle pulse.
- a_rdata  out  WIDTH  requester A: read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical signals for requester B.
- ram_in  out  WIDTH  to ram8 in.
- ram_addr  out  AW  to ram8 addr.
- ram_load  out  1  to ram8 load.
- ram_out  in  WIDTH  from ram8 outp (combinational read of ram_addr).
- init_busy  out  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- States: INIT and RUN.
- Reset (sampled high at an edge) sets:
  - state=INIT, clear counter cnt=0, rr_ptr=A.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - init_busy=1.
  - While reset is high: ram_load=0, a_gnt=b_gnt=0.
- INIT, with reset low:
  - ram_addr=cnt, ram_in=0, ram_load=1, gnts=0, init_busy=1.
  - cnt increments each cycle.
  - At cnt=DEPTH-1, the next state is RUN.
  - Exactly 8 clear cycles follow reset deassertion. Reset asserted mid-INIT restarts from cnt=0.
- RUN, arbitration (combinational, one grant per cycle):
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the side rr_ptr points to.
  - After any grant, rr_ptr moves to the other side. With no grant, rr_ptr holds.
  - Under continuous contention, grants alternate A,B,A,B...
  - a_gnt/b_gnt are combinational from the req inputs and rr_ptr. They are never both high.
- RUN, datapath:
  - ram_addr/ram_in/ram_load are muxed from the granted side. ram_load = gnt & we.
  - With no grant: ram_load=0, ram_addr=0, ram_in=0.
- Write: takes effect at the edge ending the grant cycle.
- Read:
  - ram_out is sampled at the grant-cycle edge into x_rdata.
  - x_rvalid=1 for exactly the next cycle, so read latency is 1 cycle after gnt.
  - x_rdata holds its value until the next read to that side.
- Read-after-write: a write granted in cycle N followed by a read of the same address granted in N+1 returns the new data.
- Back-to-back: a side holding req continuously with no contender is granted every cycle. Reads then produce one rvalid per cycle.
- Requests during INIT are ignored, not queued. A requester keeps req high until gnt.
- Reset mid-RUN:
  - An access granted in the same cycle as reset is not performed (ram_load=0).
  - Any pending rvalid is cleared.
- Addresses wrap naturally within AW bits. No out-of-range case exists.

Test Plan:
- Init clear: preload the RAM model with 0xFF everywhere, pulse reset 1 cycle -> init_busy high for 8 cycles, ram_addr 0..7 with ram_load=1 and ram_in=0. A reads of addr 0..7 then return 0x00 with rvalid 1 cycle after each gnt.
- Single requester: A writes 0x5A@3, then reads @3 next cycle -> a_gnt both cycles, a_rvalid in the 3rd cycle with a_rdata=0x5A. b_gnt stays 0.
- Contention: A and B both hold read requests for 6 cycles after init -> grants A,B,A,B,A,B. Each side's rvalid lags its gnt by 1 cycle; gnts never overlap.
- Simultaneous write/read: A writes 0x11@5 while B reads @5, rr_ptr=A -> A granted first. B is granted the next cycle and gets 0x11.
- Reset mid-INIT: assert reset at cnt=4 -> after release, cnt restarts at 0 and init_busy lasts a full 8 cycles.
- Reset mid-RUN: B read granted in the reset cycle -> no b_rvalid afterward. rr_ptr=A, and a new INIT runs.

Source files
------------

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter sharing one ram8 port between requesters A and B.
// Clears all words after reset, then grants one access per cycle.
module ram8_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic [WIDTH-1:0] ram_in,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out,
    output logic             init_busy
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next;
    logic          rr_ptr, rr_next;   // 0 = A has priority, 1 = B

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Clear sequencing, arbitration and RAM port muxing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rr_next    = rr_ptr;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        ram_load   = 1'b0;
        ram_addr   = '0;
        ram_in     = '0;
        case (state)
            INIT: begin
                ram_addr = cnt;
                ram_load = ~reset;
                cnt_next = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!reset) begin
                    if (a_req && (!b_req || !rr_ptr)) begin
                        a_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end
                    if (a_gnt) begin
                        ram_addr = a_addr;
                        ram_in   = a_wdata;
                        ram_load = a_we;
                        rr_next  = 1'b1;
                    end else if (b_gnt) begin
                        ram_addr = b_addr;
                        ram_in   = b_wdata;
                        ram_load = b_we;
                        rr_next  = 1'b0;
                    end
                end
            end
        endcase
    end

    assign init_busy = (state == INIT);

    // Read capture: data sampled at the end of the grant cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            rr_ptr   <= rr_next;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= ram_out;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: behavioural RAM + arbitration model checked every
// cycle, plus directed sequences with literal expectations.
module tb_ram8_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [2:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load, init_busy;
    logic [7:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [2:0] ram_addr;

    int tests = 0;
    int fails = 0;

    ram8_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load),
        .ram_out(ram_out), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // The ram8 instance the controller drives
    logic [7:0] ram_mem [8];
    initial for (int i = 0; i < 8; i++) ram_mem[i] = 8'hFF;
    assign ram_out = ram_mem[ram_addr];
    always @(posedge clk) if (ram_load) ram_mem[ram_addr] <= ram_in;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the RAM should hold and what each port should see
    bit         m_valid = 0;
    int         m_init_left;
    bit         m_rr;
    logic [7:0] m_mem [8];
    bit         m_a_rv, m_b_rv;
    logic [7:0] m_a_rd, m_b_rd;
    initial for (int i = 0; i < 8; i++) m_mem[i] = 8'hFF;

    always @(negedge clk) begin
        bit ga, gb, e_load;
        int e_addr, e_in;
        ga = 0; gb = 0; e_load = 0; e_addr = 0; e_in = 0;
        if (m_valid) begin
            if (m_init_left > 0) begin
                e_addr = 8 - m_init_left;
                e_load = !reset;
            end else if (!reset) begin
                ga = a_req && (!b_req || !m_rr);
                gb = b_req && !ga;
                if (ga) begin e_addr = a_addr; e_in = a_wdata; e_load = a_we; end
                if (gb) begin e_addr = b_addr; e_in = b_wdata; e_load = b_we; end
            end
            chk("init_busy", init_busy, m_init_left > 0);
            chk("a_gnt", a_gnt, ga);
            chk("b_gnt", b_gnt, gb);
            chk("ram_load", ram_load, e_load);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_in", ram_in, e_in);
            chk("a_rvalid", a_rvalid, m_a_rv);
            chk("b_rvalid", b_rvalid, m_b_rv);
            chk("a_rdata", a_rdata, m_a_rd);
            chk("b_rdata", b_rdata, m_b_rd);
        end
        if (reset) begin
            m_valid = 1; m_init_left = 8; m_rr = 0;
            m_a_rv = 0; m_b_rv = 0; m_a_rd = '0; m_b_rd = '0;
        end else if (m_valid) begin
            if (m_init_left > 0) begin
                m_mem[8 - m_init_left] = 8'h00;
                m_init_left--;
            end else begin
                m_a_rv = ga && !a_we;
                m_b_rv = gb && !b_we;
                if (m_a_rv) m_a_rd = m_mem[a_addr];
                if (m_b_rv) m_b_rd = m_mem[b_addr];
                if (ga && a_we) m_mem[a_addr] = a_wdata;
                if (gb && b_we) m_mem[b_addr] = b_wdata;
                if (ga || gb) m_rr = ga;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit ar, input bit aw, input int aa, input int ad,
                         input bit br, input bit bw, input int ba, input int bd);
        a_req = ar; a_we = aw; a_addr = 3'(aa); a_wdata = 8'(ad);
        b_req = br; b_we = bw; b_addr = 3'(ba); b_wdata = 8'(bd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Release reset and count the clear cycles that follow
    task automatic release_and_count(input string name);
        int n;
        n = 0;
        step(); reset = 1'b0; #1;
        while (init_busy && n < 20) begin
            chk({name, "_addr"}, ram_addr, n);
            n++;
            step(); #1;
        end
        chk({name, "_len"}, n, 8);
    endtask

    initial begin
        idle();
        step(); step();
        chk("reset_busy", init_busy, 1);
        chk("reset_load", ram_load, 0);
        release_and_count("init");

        // A reads every word back-to-back; all must be cleared
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1, 0, i, 0, 0, 0, 0, 0); else idle();
            #1;
            if (i < 8) chk("clr_gnt", a_gnt, 1);
            if (i > 0) begin
                chk("clr_rvalid", a_rvalid, 1);
                chk("clr_rdata", a_rdata, 8'h00);
            end
            step();
        end

        // Single requester write then read of the same word
        drive(1, 1, 3, 8'h5A, 0, 0, 0, 0); #1;
        chk("wr_gnt", a_gnt, 1); chk("wr_bgnt", b_gnt, 0);
        step();
        drive(1, 0, 3, 0, 0, 0, 0, 0); #1;
        chk("rd_gnt", a_gnt, 1); chk("rd_rvalid_early", a_rvalid, 0);
        step();
        idle(); #1;
        chk("raw_rvalid", a_rvalid, 1); chk("raw_rdata", a_rdata, 8'h5A);
        step();
        idle(); #1;
        chk("rvalid_pulse", a_rvalid, 0); chk("rdata_hold", a_rdata, 8'h5A);

        // Reset mid-RUN with a B read presented in the reset cycle
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 3, 0); #1;
        chk("rst_bgnt", b_gnt, 0); chk("rst_load", ram_load, 0);
        step();
        idle(); #1;
        chk("rst_brvalid", b_rvalid, 0); chk("rst_busy", init_busy, 1);
        release_and_count("reinit");

        // Contention: both sides read continuously, grants alternate from A
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1, 0, 1, 0, 1, 0, 2, 0); else idle();
            #1;
            if (i < 6) begin
                chk("cont_agnt", a_gnt, (i % 2) == 0);
                chk("cont_bgnt", b_gnt, (i % 2) == 1);
            end
            if (i > 0) begin
                chk("cont_arv", a_rvalid, ((i - 1) % 2) == 0);
                chk("cont_brv", b_rvalid, ((i - 1) % 2) == 1);
            end
            step();
        end

        // A writes 0x11@5 while B reads @5, rr points at A
        drive(1, 1, 5, 8'h11, 1, 0, 5, 0); #1;
        chk("sim_agnt", a_gnt, 1); chk("sim_bgnt", b_gnt, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 5, 0); #1;
        chk("sim_bgnt2", b_gnt, 1);
        step();
        idle(); #1;
        chk("sim_brv", b_rvalid, 1); chk("sim_brd", b_rdata, 8'h11);
        step();

        // Reset asserted at cnt=4 of a clear sequence restarts it
        reset = 1'b1; #1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("mid_init_addr", ram_addr, 4);
        reset = 1'b1;
        release_and_count("restart");

        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
